// File: rtl/wave_reader_if.sv
// Sample-memory read bus between the wave reader (master) and the
// synchronous sample table (slave).
interface wave_reader_if #(
  parameter int AW   = 5,
  parameter int SIZE = 12
) ();
  logic            read;
  logic [AW-1:0]   address;
  logic [SIZE-1:0] sample;

  modport master (output read, output address, input sample);
  modport slave  (input read, input address, output sample);
endinterface

// File: rtl/wave_reader.sv
// Phase-accumulator sequencer: steps through the waveform table at a divided
// tick rate and streams the returned samples to the output stage.
//
// state | meaning
// IDLE  | stopped, sample_out holds its last value
// RUN   | ticking; one table read per tick
// DRAIN | enable dropped, waiting for the in-flight reads to return
module wave_reader #(
  parameter int N     = 32,
  parameter int SIZE  = 12,
  parameter int ACC_W = 16,
  parameter int DIV_W = 16,
  localparam int AW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ACC_W-1:0]  step,
  input  logic [DIV_W-1:0]  div,
  wave_reader_if.master     mem,
  output logic [SIZE-1:0]   sample_out,
  output logic              sample_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [ACC_W-1:0]  phase;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic              rd_q;
  logic              rd_d1;
  logic [AW-1:0]     addr_q;

  assign mem.read    = rd_q;
  assign mem.address = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      div_q        <= '0;
      cnt          <= '0;
      rd_q         <= 1'b0;
      rd_d1        <= 1'b0;
      addr_q       <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Capture pipeline: read strobe, memory returns data, sample registered.
      rd_q         <= 1'b0;
      rd_d1        <= rd_q;
      sample_valid <= rd_d1;
      if (rd_d1)
        sample_out <= mem.sample;

      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
            phase <= '0;
            div_q <= div;
            cnt   <= div;
          end
        end
        RUN: begin
          if (!enable) begin
            if (rd_q || rd_d1) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == div_q) begin
            cnt    <= '0;
            rd_q   <= 1'b1;
            addr_q <= phase[ACC_W-1 -: AW];
            phase  <= phase + step;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Once the strobe is gone, the last sample_valid lands with IDLE.
          if (!rd_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_reader.sv
// Directed bench for wave_reader: table model 0x100+i, phase model and a
// scoreboard of expected samples with their due cycles.
module tb_wave_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] step = '0;
  logic [15:0] div = '0;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        busy;

  wave_reader_if #(.AW(5), .SIZE(12)) mem ();

  wave_reader #(.N(32), .SIZE(12), .ACC_W(16), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .step         (step),
    .div          (div),
    .mem          (mem),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem.read) mem.sample <= 12'h100 + 12'(mem.address);

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] mphase = '0;
  logic [15:0] step_prev = '0;
  int          exp_gap = 1;
  int          last_rd = 0;
  bit          have_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every read address against the phase model, every valid against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mphase    = '0;
      have_last = 0;
    end else begin
      if (sample_valid === 1'b1) begin
        check("valid_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("valid_cycle", cyc, e.due);
          check("sample_out", 32'(sample_out), 32'(e.val));
        end
      end
      if (mem.read === 1'b1) begin
        logic [4:0] a;
        a = mphase[15:11];
        check("mem_address", 32'(mem.address), 32'(a));
        sb.push_back('{cyc + 2, 12'h100 + 12'(a)});
        mphase = mphase + step_prev;
        if (have_last) check("read_period", cyc - last_rd, exp_gap);
        last_rd   = cyc;
        have_last = 1;
      end
    end
    step_prev = step;
  end

  task automatic start_run(input logic [15:0] s, input logic [15:0] d);
    @(posedge clk); #1;
    step      = s;
    div       = d;
    exp_gap   = int'(d) + 1;
    have_last = 0;
    mphase    = '0;
    enable    = 1'b1;
  endtask

  task automatic stop_run();
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_read();
    int n;
    n = 0;
    @(negedge clk);
    while (mem.read !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("read_timeout", 32'(mem.read), 32'd1);
  endtask

  initial begin
    // Asynchronous reset mid-cycle
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_read", 32'(mem.read), 32'd0);
    check("rst_mem_address", 32'(mem.address), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // div=0: one read per cycle, valids continuous
    start_run(16'h0800, 16'd0);
    repeat (6) @(posedge clk);
    repeat (30) begin
      @(negedge clk);
      check("valid_continuous", 32'(sample_valid), 32'd1);
    end
    stop_run();

    // div=3: one read in four; div change mid-run ignored
    start_run(16'h0800, 16'd3);
    repeat (20) @(posedge clk);
    #1 div = 16'd0;
    repeat (20) @(posedge clk);
    stop_run();

    // step=0x0C00: addresses 0,1,3,4,... wrapping 31->1
    start_run(16'h0C00, 16'd0);
    repeat (100) @(posedge clk);
    stop_run();

    // Drop enable right after a tick: DRAIN until the last sample returns
    start_run(16'h0800, 16'd7);
    wait_read();
    enable = 1'b0;
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_no_valid", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("drain_done_busy", 32'(busy), 32'd0);
    check("drain_last_valid", 32'(sample_valid), 32'd1);
    repeat (12) begin
      @(negedge clk);
      check("idle_no_read", 32'(mem.read), 32'd0);
    end
    check("idle_sample_held", 32'(sample_out), 32'h100);
    check("idle_addr_held", 32'(mem.address), 32'd0);

    // Reset one cycle after a read: in-flight sample is discarded
    start_run(16'h0800, 16'd3);
    wait_read();
    wait_read();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrd_busy", 32'(busy), 32'd0);
    check("midrd_sample_out", 32'(sample_out), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrd_no_valid", 32'(sample_valid), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    start_run(16'h0800, 16'd3);
    wait_read();
    check("restart_addr", 32'(mem.address), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("restart_valid", 32'(sample_valid), 32'd1);
    check("restart_sample", 32'(sample_out), 32'h100);
    stop_run();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
